frame_data_reg_bank: RTL and testbench
======================================

Name: frame_data_reg_bank

Overview:
- Parametrised successor to the per-row frame data registers: a single block holding the frame data latches for all NumRows rows of a fabric column.
- Receives configuration data as a narrow valid/ready word stream and assembles each row word from InWidth-bit beats.
- Commits each assembled word into the addressed row register, with optional row auto-increment and sticky out-of-range error reporting.
- Sits between the configuration loader and the tile frame-data inputs.

Parameters:
- FrameBitsPerRow, 32: width of one row register.
- RowSelectWidth, 5: width of row addresses.
- NumRows, 16: number of row registers.
- InWidth, 8: beat width. Must divide FrameBitsPerRow. K = FrameBitsPerRow/InWidth beats per row word.
- FirstRow, 1: row address mapped to register index 0. Valid addresses are FirstRow..FirstRow+NumRows-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- in_data  in  InWidth  data beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid&in_ready at a rising edge.
- row_load  in  1  single-cycle request to set the target row.
- row_addr  in  RowSelectWidth  target row, sampled when row_load=1.
- auto_inc  in  1  level; when 1, the target row advances after each commit.
- FrameData_O  out  NumRows*FrameBitsPerRow  concatenated row registers; register index i occupies bits [i*FrameBitsPerRow +: FrameBitsPerRow].
- commit_valid  out  1  one-cycle pulse while a commit is performed.
- commit_row  out  RowSelectWidth  row address of the current commit; valid when commit_valid=1.
- err  out  1  sticky: a commit targeted an out-of-range row.

Behaviour:
- Reset (async, RST=1):
  - All row registers = 0.
  - cur_row = FirstRow; beat_cnt = 0; assembly register = 0.
  - State = ACCEPT.
  - in_ready = 0 while RST=1; in_ready = 1 from the first cycle after deassertion.
  - commit_valid = 0, commit_row = 0, err = 0.
- States: ACCEPT, COMMIT.
- ACCEPT:
  - in_ready = !row_load (combinational).
  - Accepted beat n (0..K-1) is written to assembly bits [n*InWidth +: InWidth], so beat 0 lands in the LSBs. beat_cnt increments.
  - On acceptance of beat K-1: beat_cnt -> 0, state -> COMMIT.
- COMMIT (exactly one cycle):
  - in_ready = 0; commit_valid = 1; commit_row = cur_row.
  - If FirstRow <= cur_row < FirstRow+NumRows: row register [cur_row-FirstRow] <= assembly word at the closing edge, visible on FrameData_O the next cycle. Other rows are untouched.
  - Otherwise: no register is written and err <= 1.
  - If auto_inc=1 and no row_load: cur_row increments; after the last valid row it wraps to FirstRow. An out-of-range cur_row becomes FirstRow.
  - State -> ACCEPT.
- row_load:
  - In ACCEPT: cur_row <= row_addr; beat_cnt <= 0 (any partial word is discarded); err <= 0. Any beat offered in the same cycle is not accepted.
  - In COMMIT: the commit completes to the old cur_row first. cur_row <= row_addr (takes priority over auto_inc). err <= 0, unless this commit sets it, in which case err = 1.
- Throughput: K+1 cycles per row word under continuous in_valid.
- Latency: edge accepting the last beat -> COMMIT cycle -> row register updated at the end of that cycle. Total 2 edges.
- Reset mid-word or mid-COMMIT: everything returns to reset values immediately; partial data is discarded and no write occurs.
- Row registers hold their value indefinitely when not addressed.

Test Plan:
- Reset, then row_load row_addr=1, auto_inc=0, beats 0x11,0x22,0x33,0x44 back-to-back -> commit_valid one cycle with commit_row=1; next cycle FrameData_O[31:0]=0x44332211; all other rows 0; in_ready low only in the COMMIT cycle.
- auto_inc=1, row_load 15, two words 0xA5A5A5A5 then 0x0F0F0F0F -> row 15 (index 14)=0xA5A5A5A5 and row 16 (index 15)=0x0F0F0F0F; a third word lands in row 1 (wrap).
- row_load 3, send 2 beats 0xAA,0xBB, row_load 4, then 4 beats 0x01..0x04 -> row 3 unchanged (0); row 4=0x04030201.
- row_load 0 (below FirstRow), send a full word -> commit_valid pulses with commit_row=0, err=1, no row changes; err stays 1 after a second out-of-range word; a later row_load 2 clears err.
- in_valid and row_load asserted in the same ACCEPT cycle -> in_ready=0 and the beat is not consumed; beat_cnt restarts at 0 for the new row.
- Assert RST after 3 beats of a word -> in_ready=0 and FrameData_O all zero during reset; after release, a full word to row 1 assembles correctly from beat 0.

Source files
------------

// File: rtl/frame_data_reg_bank.sv
// Frame data latches for every row of a fabric column, loaded from a narrow valid/ready beat
// stream with per-word row commit, optional auto-increment and sticky out-of-range error.
module frame_data_reg_bank #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned RowSelectWidth  = 5,
  parameter int unsigned NumRows         = 16,
  parameter int unsigned InWidth         = 8,
  parameter int unsigned FirstRow        = 1
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [InWidth-1:0]                  in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                row_load,
  input  logic [RowSelectWidth-1:0]           row_addr,
  input  logic                                auto_inc,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData_O,
  output logic                                commit_valid,
  output logic [RowSelectWidth-1:0]           commit_row,
  output logic                                err
);

  localparam int unsigned K     = FrameBitsPerRow / InWidth;
  localparam int unsigned BeatW = (K > 1) ? $clog2(K) : 1;

  localparam logic [RowSelectWidth-1:0] FirstRowW = RowSelectWidth'(FirstRow);
  localparam logic [RowSelectWidth-1:0] LastRowW  = RowSelectWidth'(FirstRow + NumRows - 1);
  localparam logic [RowSelectWidth:0]   LoRowX    = (RowSelectWidth + 1)'(FirstRow);
  localparam logic [RowSelectWidth:0]   HiRowX    = (RowSelectWidth + 1)'(FirstRow + NumRows);
  localparam logic [BeatW-1:0]          LastBeatW = BeatW'(K - 1);

  typedef enum logic {StAccept, StCommit} state_e;

  state_e                                    r_state;
  state_e                                    w_state_next;
  logic [NumRows-1:0][FrameBitsPerRow-1:0]   r_rows;
  logic [FrameBitsPerRow-1:0]                r_asm;
  logic [BeatW-1:0]                          r_beat_cnt;
  logic [RowSelectWidth-1:0]                 r_cur_row;
  logic                                      r_err;

  logic                                      w_accept;
  logic                                      w_commit;
  logic                                      w_ready;
  logic                                      w_last_beat;
  logic                                      w_in_range;
  logic [RowSelectWidth-1:0]                 w_idx;
  logic [RowSelectWidth-1:0]                 w_row_inc;

  assign w_last_beat = (r_beat_cnt == LastBeatW);
  assign w_in_range  = ({1'b0, r_cur_row} >= LoRowX) && ({1'b0, r_cur_row} < HiRowX);
  assign w_idx       = r_cur_row - FirstRowW;
  // Wrap after the last valid row; an out-of-range row restarts at the first row.
  assign w_row_inc   = (w_in_range && (r_cur_row != LastRowW)) ? r_cur_row + 1'b1 : FirstRowW;

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      StAccept: begin
        w_ready  = !row_load;
        w_accept = in_valid && !row_load;
        if (w_accept && w_last_beat) begin
          w_state_next = StCommit;
        end
      end
      StCommit: begin
        w_commit     = 1'b1;
        w_state_next = StAccept;
      end
      default: w_state_next = StAccept;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= StAccept;
      r_rows     <= '0;
      r_asm      <= '0;
      r_beat_cnt <= '0;
      r_cur_row  <= FirstRowW;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        for (int unsigned i = 0; i < K; i++) begin
          if (r_beat_cnt == BeatW'(i)) begin
            r_asm[i*InWidth +: InWidth] <= in_data;
          end
        end
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
      end else if (row_load && (r_state == StAccept)) begin
        r_beat_cnt <= '0;
      end

      if (w_commit) begin
        for (int unsigned i = 0; i < NumRows; i++) begin
          if (w_in_range && (w_idx == RowSelectWidth'(i))) begin
            r_rows[i] <= r_asm;
          end
        end
        if (!w_in_range) begin
          r_err <= 1'b1;
        end else if (row_load) begin
          r_err <= 1'b0;
        end
        if (row_load) begin
          r_cur_row <= row_addr;
        end else if (auto_inc) begin
          r_cur_row <= w_row_inc;
        end
      end else if (row_load) begin
        r_cur_row <= row_addr;
        r_err     <= 1'b0;
      end
    end
  end

  assign in_ready     = w_ready && !RST;
  assign commit_valid = w_commit;
  assign commit_row   = w_commit ? r_cur_row : '0;
  assign err          = r_err;
  assign FrameData_O  = r_rows;

endmodule

// File: tb/tb_frame_data_reg_bank.sv
// Self-checking bench for frame_data_reg_bank: directed scenarios plus a random phase,
// compared every cycle against a word-level reference model.
module tb_frame_data_reg_bank;

  localparam int W  = 32;
  localparam int RW = 5;
  localparam int NR = 16;
  localparam int IW = 8;
  localparam int FR = 1;
  localparam int K  = W / IW;

  logic              CLK;
  logic              RST;
  logic [IW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic              row_load;
  logic [RW-1:0]     row_addr;
  logic              auto_inc;
  logic [NR*W-1:0]   FrameData_O;
  logic              commit_valid;
  logic [RW-1:0]     commit_row;
  logic              err;

  frame_data_reg_bank #(
    .FrameBitsPerRow(W),
    .RowSelectWidth (RW),
    .NumRows        (NR),
    .InWidth        (IW),
    .FirstRow       (FR)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .row_load    (row_load),
    .row_addr    (row_addr),
    .auto_inc    (auto_inc),
    .FrameData_O (FrameData_O),
    .commit_valid(commit_valid),
    .commit_row  (commit_row),
    .err         (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: rows, target row, beats of the word in progress, pending commit.
  logic [W-1:0]  m_rows [NR];
  int            m_cur;
  logic [IW-1:0] m_beats [$];
  logic [W-1:0]  m_word;
  bit            m_commit;
  bit            m_err;

  function automatic bit in_rng(int r);
    return (r >= FR) && (r < FR + NR);
  endfunction

  function automatic void chk(string tag, logic [NR*W-1:0] obs, logic [NR*W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_rows[i] = '0;
    m_cur = FR;
    m_beats.delete();
    m_word = '0;
    m_commit = 0;
    m_err = 0;
  endfunction

  function automatic logic [NR*W-1:0] model_frame();
    logic [NR*W-1:0] f;
    for (int i = 0; i < NR; i++) f[i*W +: W] = m_rows[i];
    return f;
  endfunction

  // Applies one rising edge to the model using the current inputs.
  function automatic void model_edge();
    if (m_commit) begin
      if (in_rng(m_cur)) m_rows[m_cur - FR] = m_word;
      if (!in_rng(m_cur)) m_err = 1;
      else if (row_load) m_err = 0;
      if (row_load) m_cur = int'(row_addr);
      else if (auto_inc) m_cur = (in_rng(m_cur) && m_cur < FR + NR - 1) ? m_cur + 1 : FR;
      m_commit = 0;
    end else if (row_load) begin
      m_cur = int'(row_addr);
      m_beats.delete();
      m_err = 0;
    end else if (in_valid) begin
      m_beats.push_back(in_data);
      if (m_beats.size() == K) begin
        m_word = '0;
        for (int n = 0; n < K; n++) m_word = m_word | (W'(m_beats[n]) << (n * IW));
        m_beats.delete();
        m_commit = 1;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("in_ready", NR*W'(in_ready), NR*W'(!RST && !m_commit && !row_load));
    chk("commit_valid", NR*W'(commit_valid), NR*W'(m_commit));
    if (m_commit) chk("commit_row", NR*W'(commit_row), NR*W'(m_cur[RW-1:0]));
    chk("err", NR*W'(err), NR*W'(m_err));
    chk("frame", FrameData_O, model_frame());
  endtask

  task automatic tick();
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    #1;
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic load_row(input int r);
    row_load = 1'b1;
    row_addr = RW'(r);
    tick();
    row_load = 1'b0;
  endtask

  task automatic send_beat(input logic [IW-1:0] b);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (m_commit && guard < 8) begin
      tick();
      guard++;
    end
    if (guard >= 8) chk("beat_timeout", 1, 0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int n = 0; n < K; n++) send_beat(w[n*IW +: IW]);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    RST      = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    row_load = 1'b0;
    row_addr = '0;
    auto_inc = 1'b0;
    model_reset();
    do_reset();
    tick();

    // Basic word into row 1.
    load_row(1);
    send_word(32'h44332211);
    tick();
    chk("row1_word", NR*W'(FrameData_O[31:0]), NR*W'(32'h44332211));

    // Auto-increment across the top row and wrap to row 1.
    auto_inc = 1'b1;
    load_row(15);
    send_word(32'hA5A5A5A5);
    send_word(32'h0F0F0F0F);
    send_word(32'h12345678);
    tick();
    chk("row15_word", NR*W'(FrameData_O[14*W +: W]), NR*W'(32'hA5A5A5A5));
    chk("row16_word", NR*W'(FrameData_O[15*W +: W]), NR*W'(32'h0F0F0F0F));
    chk("wrap_row1", NR*W'(FrameData_O[31:0]), NR*W'(32'h12345678));
    auto_inc = 1'b0;

    // Partial word discarded by a new row_load.
    load_row(3);
    send_beat(8'hAA);
    send_beat(8'hBB);
    load_row(4);
    send_word(32'h04030201);
    tick();
    chk("row3_untouched", NR*W'(FrameData_O[2*W +: W]), '0);
    chk("row4_word", NR*W'(FrameData_O[3*W +: W]), NR*W'(32'h04030201));

    // Out-of-range row sets sticky err; row_load clears it.
    load_row(0);
    send_word(32'hDEADBEEF);
    send_word(32'hCAFEF00D);
    chk("err_sticky", NR*W'(err), NR*W'(1));
    load_row(2);
    chk("err_cleared", NR*W'(err), '0);

    // Beat offered together with row_load is not consumed.
    in_valid = 1'b1;
    in_data  = 8'h99;
    row_load = 1'b1;
    row_addr = RW'(5);
    tick();
    row_load = 1'b0;
    in_valid = 1'b0;
    send_word(32'h55667788);
    tick();
    chk("row5_word", NR*W'(FrameData_O[4*W +: W]), NR*W'(32'h55667788));

    // Reset in the middle of a word.
    load_row(6);
    send_beat(8'h01);
    send_beat(8'h02);
    send_beat(8'h03);
    do_reset();
    chk("frame_after_reset", FrameData_O, '0);
    tick();
    send_word(32'hC0DEC0DE);
    tick();
    chk("row1_after_reset", NR*W'(FrameData_O[31:0]), NR*W'(32'hC0DEC0DE));

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_data  = IW'($urandom);
      row_load = 1'($urandom_range(0, 15) == 0);
      row_addr = RW'($urandom_range(0, 20));
      auto_inc = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    row_load = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
